dmem_port_ctrl: RTL and testbench
=================================

# dmem_port_ctrl

Single-port data-memory controller for the M stage of the dual-issue pipeline. It takes the load/store request from whichever pipe the hazard unit currently names as `MemoryUser` and runs a req/ack transaction to a variable-latency data memory. It returns read data to the owning pipe and drives `MemReady` back to the hazard unit, which uses it to hold or release the E/M stalls and to step its dual-access sequence.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum cycles in REQ waiting for `mem_ack` before abort.
- `TW`, 8: width of the timeout counter. Must satisfy 2^TW > TIMEOUT.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `MemoryUser` in 1: 0 = pipe 1 owns the port, 1 = pipe 2 owns it.
- `MemtoRegM_1`, `MemWriteM_1` in 1 each: pipe 1 load/store in M.
- `ALUOutM_1` in 32: pipe 1 byte address.
- `WriteDataM_1` in 32: pipe 1 store data.
- `MemtoRegM_2`, `MemWriteM_2`, `ALUOutM_2`, `WriteDataM_2`: same as above, for pipe 2.
- `ReadDataM_1`, `ReadDataM_2` out 32: registered load result per pipe.
- `MemReady` out 1: access complete, or no access pending for the current owner.
- `MemErr` out 1: sticky timeout flag.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 32, `mem_wdata` out 32: backing-memory request.
- `mem_ack` in 1, `mem_rdata` in 32: backing-memory completion and read data.

## Operation
- Owner selection: `sel_rd`, `sel_wr`, `sel_addr` and `sel_wdata` are muxed from pipe 1 or pipe 2 by `MemoryUser`.
- `sel_req` = `sel_rd | sel_wr`. If both `sel_rd` and `sel_wr` are set, it is treated as a write.
- States: IDLE, REQ, DONE.
- IDLE:
  - If `sel_req`: latch `owner`=`MemoryUser`, `we`=`sel_wr`, `mem_addr`={`sel_addr[31:2]`,2'b00}, `mem_wdata`=`sel_wdata`. Set `mem_req`=1, clear the timer, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` hold stable until ack.
  - Timer increments each cycle.
  - On `mem_ack`: if it is a read, `ReadDataM_<owner>` <= `mem_rdata`. Drop `mem_req` and go to DONE.
  - On timer == TIMEOUT with no ack: drop `mem_req`, set `MemErr`, go to DONE. A read in this case loads `ReadDataM_<owner>` <= 0.
- DONE: one cycle, then IDLE unconditionally.
- `MemReady` = (state==DONE) | (state==IDLE & !`sel_req`). It is combinational from the state register and the M-stage registers only, so there is no path from `mem_*`.
- The non-owner's `ReadDataM` is never modified.
- Writes never modify either `ReadDataM`.
- Re-access: a request still present in the IDLE that follows DONE is a new access. This case only arises if M is held for an unrelated reason. A repeated load or store is idempotent and accepted.
- `mem_ack` is ignored outside REQ.

## Timing
- Reset values: state=IDLE, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `ReadDataM_1`=0, `ReadDataM_2`=0, `MemErr`=0, timer=0.
- `MemReady` is therefore 1 after reset when no request is present.
- Reset mid-transaction: at that edge, go to IDLE with `mem_req`=0. A late ack is ignored.
- Latency: request visible in cycle 0, `mem_req` high from cycle 1, ack earliest sampled at the end of cycle 1. DONE (`MemReady`=1) is then cycle 2, and `ReadDataM` is valid from cycle 2.
- `MemReady` is 0 from cycle 0 through the last REQ cycle. That is `2 + ack_wait` cycles low for any access.
- Owner switch: `MemoryUser` changing while in REQ or DONE has no effect. It is sampled only in IDLE.
- Timeout: `mem_req` is high for exactly TIMEOUT+1 cycles, then DONE. `MemErr` is high from the DONE cycle until reset.

## Test plan
- Pipe 1 load: `MemoryUser`=0, `MemtoRegM_1`=1, `ALUOutM_1`=0x0000_0104, ack on the 3rd REQ cycle with `mem_rdata`=0xCAFEF00D. Required: `mem_addr`=0x104; `MemReady` low for 4 cycles then high for 1; `ReadDataM_1`=0xCAFEF00D; `ReadDataM_2` unchanged.
- Pipe 2 store, misaligned: `MemoryUser`=1, `MemWriteM_2`=1, `ALUOutM_2`=0x207, `WriteDataM_2`=0x11223344, ack on the 1st REQ cycle. Required: `mem_we`=1, `mem_addr`=0x204, `mem_wdata`=0x11223344; both `ReadDataM` unchanged.
- Dual-access sequence: both pipes load. `MemoryUser`=0, then it switches to 1 during REQ and stays 1. Required: first transaction uses pipe 1's address; the second starts from the IDLE after DONE with pipe 2's address; each `ReadDataM` gets its own data.
- Timeout with TIMEOUT=4 and no ack on a load. Required: `mem_req` high for 5 cycles, then DONE; `MemErr`=1 and stays 1; `ReadDataM_<owner>`=0.
- Reset in the 2nd REQ cycle, followed by an ack one cycle later. Required: `mem_req`=0 after the reset edge; state IDLE; `ReadDataM` not updated by the late ack.
- Idle/no-request: no MemtoReg/MemWrite asserted for 10 cycles. Required: `MemReady`=1 throughout, `mem_req`=0.

Source files
------------

// File: rtl/dmem_port_ctrl_if.sv
// M-stage load/store and backing-memory signals of the data-memory port.
// The controller takes the master view; pipeline, hazard unit and memory take slave.
interface dmem_port_ctrl_if;
  logic        MemoryUser;
  logic        MemtoRegM_1, MemWriteM_1;
  logic [31:0] ALUOutM_1, WriteDataM_1;
  logic        MemtoRegM_2, MemWriteM_2;
  logic [31:0] ALUOutM_2, WriteDataM_2;
  logic [31:0] ReadDataM_1, ReadDataM_2;
  logic        MemReady, MemErr;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    input  MemoryUser,
    input  MemtoRegM_1, MemWriteM_1, ALUOutM_1, WriteDataM_1,
    input  MemtoRegM_2, MemWriteM_2, ALUOutM_2, WriteDataM_2,
    output ReadDataM_1, ReadDataM_2, MemReady, MemErr,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    output MemoryUser,
    output MemtoRegM_1, MemWriteM_1, ALUOutM_1, WriteDataM_1,
    output MemtoRegM_2, MemWriteM_2, ALUOutM_2, WriteDataM_2,
    input  ReadDataM_1, ReadDataM_2, MemReady, MemErr,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dmem_port_ctrl.sv
// Single-port data-memory controller: runs one req/ack access for the pipe that
// currently owns the port, with a bounded wait and sticky timeout error.
module dmem_port_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic       clk,
  input  logic       reset,
  dmem_port_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state, stateNext;
  logic              selRd, selWr, selReq;
  logic [31:0]       selAddr, selWdata;
  logic              owner;
  logic [TW-1:0]     timer;
  logic              memReq, memWe, memErr;
  logic [31:0]       memAddr, memWdata;
  logic [1:0][31:0]  readData;
  logic              ackHit, timeoutHit, reqEnd;

  always_comb begin
    selRd    = bus.MemoryUser ? bus.MemtoRegM_2  : bus.MemtoRegM_1;
    selWr    = bus.MemoryUser ? bus.MemWriteM_2  : bus.MemWriteM_1;
    selAddr  = bus.MemoryUser ? bus.ALUOutM_2    : bus.ALUOutM_1;
    selWdata = bus.MemoryUser ? bus.WriteDataM_2 : bus.WriteDataM_1;
    selReq   = selRd | selWr;
  end

  // ack wins over a timeout landing in the same cycle
  assign ackHit     = (state == REQ) && bus.mem_ack;
  assign timeoutHit = (state == REQ) && !bus.mem_ack && (timer == TW'(TIMEOUT));
  assign reqEnd     = ackHit | timeoutHit;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (selReq) stateNext = REQ;
      REQ:     if (reqEnd) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      owner    <= 1'b0;
      timer    <= '0;
      memErr   <= 1'b0;
      readData <= '0;
    end else begin
      case (state)
        IDLE: if (selReq) begin
          owner    <= bus.MemoryUser;
          memWe    <= selWr;
          memAddr  <= {selAddr[31:2], 2'b00};
          memWdata <= selWdata;
          memReq   <= 1'b1;
          timer    <= '0;
        end
        REQ: begin
          timer <= timer + TW'(1);
          if (reqEnd)     memReq <= 1'b0;
          if (timeoutHit) memErr <= 1'b1;
          // aborted loads return zero so the pipe never sees stale data
          if (reqEnd && !memWe)
            readData[owner] <= ackHit ? bus.mem_rdata : 32'h0;
        end
        default: ;
      endcase
    end
  end

  assign bus.MemReady    = (state == DONE) || ((state == IDLE) && !selReq);
  assign bus.MemErr      = memErr;
  assign bus.mem_req     = memReq;
  assign bus.mem_we      = memWe;
  assign bus.mem_addr    = memAddr;
  assign bus.mem_wdata   = memWdata;
  assign bus.ReadDataM_1 = readData[0];
  assign bus.ReadDataM_2 = readData[1];

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Directed and randomized checks of dmem_port_ctrl against a transaction-level model.
module tb_dmem_port_ctrl;
  localparam int T = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_port_ctrl_if bus();

  dmem_port_ctrl #(.TIMEOUT(T), .TW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] expRd [2];
  logic        expErr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clearIn();
    bus.MemoryUser   = 1'b0;
    bus.MemtoRegM_1  = 1'b0; bus.MemWriteM_1 = 1'b0;
    bus.ALUOutM_1    = 32'h0; bus.WriteDataM_1 = 32'h0;
    bus.MemtoRegM_2  = 1'b0; bus.MemWriteM_2 = 1'b0;
    bus.ALUOutM_2    = 32'h0; bus.WriteDataM_2 = 32'h0;
    bus.mem_ack      = 1'b0;
    bus.mem_rdata    = 32'h0;
  endtask

  task automatic chkData(input string tag);
    chk({tag, "_rd1"}, bus.ReadDataM_1, expRd[0]);
    chk({tag, "_rd2"}, bus.ReadDataM_2, expRd[1]);
  endtask

  // One access from an IDLE cycle: ackAt = REQ cycle carrying the ack (never if out of range),
  // switchAt = REQ cycle where MemoryUser flips, clr = drop requests in the DONE cycle.
  task automatic access(input logic user,
                        input logic rd1, input logic wr1, input logic [31:0] a1, input logic [31:0] d1,
                        input logic rd2, input logic wr2, input logic [31:0] a2, input logic [31:0] d2,
                        input int ackAt, input logic [31:0] rdata, input int switchAt, input logic clr);
    logic        isWr, isRd, acked;
    logic [31:0] ea, ed;
    int          n;
    bit          done;
    isWr = user ? wr2 : wr1;
    isRd = (user ? rd2 : rd1) && !isWr;
    ea   = (user ? a2 : a1) & 32'hFFFF_FFFC;
    ed   = user ? d2 : d1;
    bus.MemoryUser  = user;
    bus.MemtoRegM_1 = rd1; bus.MemWriteM_1 = wr1; bus.ALUOutM_1 = a1; bus.WriteDataM_1 = d1;
    bus.MemtoRegM_2 = rd2; bus.MemWriteM_2 = wr2; bus.ALUOutM_2 = a2; bus.WriteDataM_2 = d2;
    bus.mem_ack     = 1'b0;
    @(negedge clk);
    chk("c0_ready", {31'h0, bus.MemReady}, 32'd0);
    chk("c0_req",   {31'h0, bus.mem_req},  32'd0);
    n = 0; done = 0; acked = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      n++;
      if (n == switchAt) bus.MemoryUser = ~user;
      acked         = (n == ackAt);
      bus.mem_ack   = acked;
      bus.mem_rdata = acked ? rdata : $urandom;
      @(negedge clk);
      chk("req_req",   {31'h0, bus.mem_req},  32'd1);
      chk("req_ready", {31'h0, bus.MemReady}, 32'd0);
      chk("req_we",    {31'h0, bus.mem_we},   {31'h0, isWr});
      chk("req_addr",  bus.mem_addr, ea);
      if (isWr) chk("req_wdata", bus.mem_wdata, ed);
      done = acked || (n == T + 1);
    end
    if (isRd) expRd[user] = acked ? rdata : 32'h0;
    if (!acked) expErr = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    if (clr) clearIn();
    @(negedge clk);
    chk("done_ready", {31'h0, bus.MemReady}, 32'd1);
    chk("done_req",   {31'h0, bus.mem_req},  32'd0);
    chk("done_err",   {31'h0, bus.MemErr},   {31'h0, expErr});
    chkData("done");
    @(posedge clk); #1;
  endtask

  initial begin
    logic        u, r1, w1, r2, w2;
    clearIn();
    expRd[0] = 32'h0; expRd[1] = 32'h0; expErr = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   {31'h0, bus.mem_req},  32'd0);
    chk("rst_we",    {31'h0, bus.mem_we},   32'd0);
    chk("rst_addr",  bus.mem_addr,  32'h0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    chk("rst_err",   {31'h0, bus.MemErr},   32'd0);
    chk("rst_ready", {31'h0, bus.MemReady}, 32'd1);
    chkData("rst");
    @(posedge clk); #1;
    reset = 1'b0;

    // idle with stray acks: nothing may move
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.mem_ack   = 1'($urandom_range(0, 1));
      bus.mem_rdata = $urandom;
      @(negedge clk);
      chk("idle_ready", {31'h0, bus.MemReady}, 32'd1);
      chk("idle_req",   {31'h0, bus.mem_req},  32'd0);
      chkData("idle");
    end
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;

    access(1'b0, 1'b1, 1'b0, 32'h0000_0104, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
           3, 32'hCAFEF00D, 0, 1'b1);
    access(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0207, 32'h11223344,
           1, 32'hDEADBEEF, 0, 1'b1);
    access(1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 1'b1, 1'b0, 32'h0000_040C, 32'h0,
           2, 32'hAAAA5555, 1, 1'b0);
    access(1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 1'b1, 1'b0, 32'h0000_040C, 32'h0,
           1, 32'h5555AAAA, 0, 1'b1);
    access(1'b0, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
           0, 32'h0, 0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      u  = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
      r2 = 1'($urandom_range(0, 1)); w2 = 1'($urandom_range(0, 1));
      if (!u && !(r1 | w1)) r1 = 1'b1;
      if (u && !(r2 | w2))  r2 = 1'b1;
      access(u, r1, w1, $urandom, $urandom, r2, w2, $urandom, $urandom,
             $urandom_range(1, T + 2), $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // reset during the 2nd REQ cycle, then an ack that arrives too late
    clearIn();
    bus.MemoryUser = 1'b1; bus.MemtoRegM_2 = 1'b1; bus.ALUOutM_2 = 32'h0000_0610;
    @(negedge clk);
    chk("mr_c0_ready", {31'h0, bus.MemReady}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mr_req2", {31'h0, bus.mem_req}, 32'd1);
    reset = 1'b1;
    clearIn();
    @(posedge clk); #1;
    reset = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BAD_0BAD;
    expRd[0] = 32'h0; expRd[1] = 32'h0; expErr = 1'b0;
    @(negedge clk);
    chk("mr_req",   {31'h0, bus.mem_req},  32'd0);
    chk("mr_ready", {31'h0, bus.MemReady}, 32'd1);
    chk("mr_err",   {31'h0, bus.MemErr},   32'd0);
    chkData("mr");
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("mr_late_req", {31'h0, bus.mem_req}, 32'd0);
    chkData("mr_late");
    @(posedge clk); #1;

    access(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0700, 32'h0,
           2, 32'h1234_5678, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
